cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle instruction-cycle controller that drives the control pins of PC, AR, DR and the 8x16 register bank, plus the memory request handshake.
- Sequences fetch, decode, execute, memory access and writeback for a 16-bit instruction word.
- Sits between the memory interface and the special-register/register-bank datapath; it owns no datapath registers except a latched instruction copy.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles to wait for mem_ack before declaring a bus error (>=1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  16  DR output; instruction word, valid the cycle after a fetch dr_en
- mem_ack  in  1  memory completes the current request (single-cycle pulse)
- mem_req  out  1  memory request; held high until mem_ack or timeout
- mem_we  out  1  1=write (store), 0=read; valid while mem_req=1
- pc_en, pc_inc, pc_write  out  1 each  PC control
- ar_en  out  1  AR load
- ar_src  out  1  AR source mux: 0=PC, 1=reg-bank d0
- dr_en  out  1  DR load from memory data
- rb_en, rb_rw  out  1 each  register-bank enable / write
- rb_sel, rb_setd0, rb_setd1  out  3 each  register-bank write select and read-port selects
- wb_src  out  1  reg-bank write data mux: 0=ALU result, 1=DR
- halted  out  1  level, high in HALTED
- bus_err  out  1  one-cycle pulse on memory timeout
- illegal  out  1  one-cycle pulse on undefined opcode
- retired  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W

Behaviour:
- Instruction fields: op=instr[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3]. The fields are latched into ir_q in DECODE; EXEC, MWAIT and WB use only ir_q.
- Opcodes:
  - 0 NOP
  - 1 ALU
  - 2 LOAD rd<=M[rs1]
  - 3 STORE M[rs1]<=rd
  - 4 JMP PC<=rs1
  - 15 HALT
  - Any other opcode is treated as NOP and pulses illegal.
- Default value of every control output is 0 unless the state lists it. On reset all outputs are 0, state=FETCH, retired=0, timer=0, ir_q=0.
- rb_en is 1 in every state that consumes d0/d1, because bank reads are gated by en. In those states rb_rw=0 unless a write is listed.
- State FETCH: ar_en=1, ar_src=0 -> FWAIT.
- State FWAIT: mem_req=1, mem_we=0.
  - On mem_ack: dr_en=1 -> DECODE.
- State DECODE: ir_q<=instr; pc_en=1, pc_inc=1 (PC+2) -> EXEC.
- State EXEC, by opcode:
  - NOP/illegal: retire -> FETCH.
  - ALU: rb_en=1, rb_setd0=rs1, rb_setd1=rs2, rb_rw=1, rb_sel=rd, wb_src=0; retire -> FETCH.
  - LOAD/STORE: rb_en=1, rb_setd0=rs1, ar_en=1, ar_src=1 -> MWAIT.
  - JMP: rb_en=1, rb_setd0=rs1, pc_en=1, pc_write=1; retire -> FETCH.
  - HALT: retire -> HALTED.
- State MWAIT: mem_req=1, mem_we=(op==STORE); for STORE also rb_en=1, rb_setd1=rd (store data).
  - On mem_ack with LOAD: dr_en=1 -> WB.
  - On mem_ack with STORE: retire -> FETCH.
- State WB: rb_en=1, rb_rw=1, rb_sel=rd, wb_src=1; retire -> FETCH.
- State HALTED: halted=1, all other controls 0. Only rst exits.
- Latency without wait states: NOP/ALU/JMP 4 cycles; STORE 5 cycles; LOAD 6 cycles.
- Timeout:
  - The timer clears on entry to FWAIT/MWAIT and increments each cycle without mem_ack.
  - If it reaches MEM_TIMEOUT with no ack: bus_err=1 for one cycle, mem_req drops, -> HALTED.
  - mem_ack arriving in the same cycle as the timeout wins (no error).
- mem_ack outside FWAIT/MWAIT is ignored.
- "Retire" means retired increments by 1 in that cycle; 0xFFFF wraps to 0.
- rst mid-transaction: immediate return to reset values next edge; mem_req deasserts and the outstanding access is abandoned.

Decomposition:
- Package cpu_seq_pkg holds:
  - opcode constants (OP_NOP..OP_HALT)
  - state encoding (FETCH, FWAIT, DECODE, EXEC, MWAIT, WB, HALTED)
  - instruction field bit positions
- Sub-module seq_timer: clearable saturating wait counter with a terminal-count flag, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset then ack every request after 1 cycle, instr=0x1298 (ALU rd=1, rs1=2, rs2=3) -> in EXEC rb_rw=1, rb_sel=1, setd0=2, setd1=3, wb_src=0; retired=1.
- LOAD instr=0x2A80 (rd=5, rs1=2), ack delayed 3 cycles -> mem_req held 3 cycles in MWAIT with mem_we=0; WB cycle has rb_sel=5, wb_src=1; total 9 cycles.
- STORE instr=0x3C40 (rd=6, rs1=1) -> in MWAIT: mem_we=1, rb_setd1=6; in EXEC: ar_src=1, setd0=1; no WB state visited.
- JMP instr=0x4080 (rs1=2) -> in EXEC: pc_write=1, pc_inc=0, setd0=2; next FETCH has ar_src=0.
- MEM_TIMEOUT=4, never ack -> bus_err pulses exactly once after 4 FWAIT cycles; halted=1 thereafter; rst returns to FETCH with retired=0.
- instr=0x7000 then 0xF000 -> illegal pulses once in EXEC; HALT gives halted=1 and retired=2; asserting rst during MWAIT clears mem_req on the next edge.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the instruction-cycle sequencer: opcodes, FSM states,
// instruction field positions and the registered control-word layout.
package cpu_seq_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;
    localparam int REG_W   = 3;

    // LSB position of each instruction field
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_NOP   = 4'h0;
    localparam opcode_t OP_ALU   = 4'h1;
    localparam opcode_t OP_LOAD  = 4'h2;
    localparam opcode_t OP_STORE = 4'h3;
    localparam opcode_t OP_JMP   = 4'h4;
    localparam opcode_t OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        FETCH,
        FWAIT,
        DECODE,
        EXEC,
        MWAIT,
        WB,
        HALTED
    } state_t;

    typedef struct packed {
        opcode_t          op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } ir_t;

    typedef struct packed {
        logic             mem_req;
        logic             mem_we;
        logic             pc_en;
        logic             pc_inc;
        logic             pc_write;
        logic             ar_en;
        logic             ar_src;
        logic             dr_arm;
        logic             rb_en;
        logic             rb_rw;
        logic [REG_W-1:0] rb_sel;
        logic [REG_W-1:0] rb_setd0;
        logic [REG_W-1:0] rb_setd1;
        logic             wb_src;
        logic             halted;
    } ctl_t;

    function automatic ir_t decode_instr(input logic [INSTR_W-1:0] w);
        ir_t f;
        f.op  = w[OP_LSB +: OP_W];
        f.rd  = w[RD_LSB +: REG_W];
        f.rs1 = w[RS1_LSB +: REG_W];
        f.rs2 = w[RS2_LSB +: REG_W];
        return f;
    endfunction

    function automatic logic is_legal(input opcode_t op);
        return (op == OP_NOP) || (op == OP_ALU) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/cpu_sequencer_timer.sv
// Clearable saturating wait counter; tc flags the last cycle of the memory
// wait allowance, so a missing ack in that cycle is a timeout.
module seq_timer
    import cpu_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int            CW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (inc && (count_q != LIMIT)) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign tc = (count_q == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute controller driving PC, AR, DR and the
// register bank, plus the memory request handshake with timeout.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 pc_en,
    output logic                 pc_inc,
    output logic                 pc_write,
    output logic                 ar_en,
    output logic                 ar_src,
    output logic                 dr_en,
    output logic                 rb_en,
    output logic                 rb_rw,
    output logic [REG_W-1:0]     rb_sel,
    output logic [REG_W-1:0]     rb_setd0,
    output logic [REG_W-1:0]     rb_setd1,
    output logic                 wb_src,
    output logic                 halted,
    output logic                 bus_err,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retired
);

    state_t           state_q;
    ir_t              ir_q;
    ctl_t             ctl_q;
    logic [CNT_W-1:0] retired_q;
    logic             bus_err_q;
    logic             illegal_q;
    logic             waiting;
    logic             timer_tc;

    // Control word to present while sitting in state s for instruction ir.
    function automatic ctl_t ctl_for(input state_t s, input ir_t ir);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:  c.ar_en = 1'b1;
            FWAIT: begin
                c.mem_req = 1'b1;
                c.dr_arm  = 1'b1;
            end
            DECODE: begin
                c.pc_en  = 1'b1;
                c.pc_inc = 1'b1;
            end
            EXEC: begin
                case (ir.op)
                    OP_ALU: begin
                        c.rb_en    = 1'b1;
                        c.rb_rw    = 1'b1;
                        c.rb_sel   = ir.rd;
                        c.rb_setd0 = ir.rs1;
                        c.rb_setd1 = ir.rs2;
                    end
                    OP_LOAD, OP_STORE: begin
                        c.rb_en    = 1'b1;
                        c.rb_setd0 = ir.rs1;
                        c.ar_en    = 1'b1;
                        c.ar_src   = 1'b1;
                    end
                    OP_JMP: begin
                        c.rb_en    = 1'b1;
                        c.rb_setd0 = ir.rs1;
                        c.pc_en    = 1'b1;
                        c.pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            MWAIT: begin
                c.mem_req = 1'b1;
                c.mem_we  = (ir.op == OP_STORE);
                c.dr_arm  = (ir.op == OP_LOAD);
                if (ir.op == OP_STORE) begin
                    c.rb_en    = 1'b1;
                    c.rb_setd1 = ir.rd;
                end
            end
            WB: begin
                c.rb_en  = 1'b1;
                c.rb_rw  = 1'b1;
                c.rb_sel = ir.rd;
                c.wb_src = 1'b1;
            end
            HALTED: c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    assign waiting = (state_q == FWAIT) || (state_q == MWAIT);

    seq_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (~waiting),
        .inc   (waiting & ~mem_ack),
        .tc    (timer_tc)
    );

    // NOTE: every register here is written with <= so all branches see the
    // pre-edge state; outputs are loaded with the control word of the state
    // being entered, so they change exactly when the state does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            ctl_q     <= '0;
            retired_q <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    state_q <= FWAIT;
                    ctl_q   <= ctl_for(FWAIT, ir_q);
                end
                FWAIT: begin
                    if (mem_ack) begin
                        state_q <= DECODE;
                        ctl_q   <= ctl_for(DECODE, ir_q);
                    end else if (timer_tc) begin
                        state_q   <= HALTED;
                        ctl_q     <= ctl_for(HALTED, ir_q);
                        bus_err_q <= 1'b1;
                    end
                end
                DECODE: begin
                    ir_q      <= decode_instr(instr);
                    illegal_q <= ~is_legal(instr[OP_LSB +: OP_W]);
                    state_q   <= EXEC;
                    ctl_q     <= ctl_for(EXEC, decode_instr(instr));
                end
                EXEC: begin
                    case (ir_q.op)
                        OP_LOAD, OP_STORE: begin
                            state_q <= MWAIT;
                            ctl_q   <= ctl_for(MWAIT, ir_q);
                        end
                        OP_HALT: begin
                            state_q   <= HALTED;
                            ctl_q     <= ctl_for(HALTED, ir_q);
                            retired_q <= retired_q + CNT_W'(1);
                        end
                        default: begin
                            state_q   <= FETCH;
                            ctl_q     <= ctl_for(FETCH, ir_q);
                            retired_q <= retired_q + CNT_W'(1);
                        end
                    endcase
                end
                MWAIT: begin
                    if (mem_ack) begin
                        if (ir_q.op == OP_LOAD) begin
                            state_q <= WB;
                            ctl_q   <= ctl_for(WB, ir_q);
                        end else begin
                            state_q   <= FETCH;
                            ctl_q     <= ctl_for(FETCH, ir_q);
                            retired_q <= retired_q + CNT_W'(1);
                        end
                    end else if (timer_tc) begin
                        state_q   <= HALTED;
                        ctl_q     <= ctl_for(HALTED, ir_q);
                        bus_err_q <= 1'b1;
                    end
                end
                WB: begin
                    state_q   <= FETCH;
                    ctl_q     <= ctl_for(FETCH, ir_q);
                    retired_q <= retired_q + CNT_W'(1);
                end
                HALTED: ;
                default: begin
                    state_q <= FETCH;
                    ctl_q   <= ctl_for(FETCH, ir_q);
                end
            endcase
        end
    end

    // DR must load in the very cycle the ack arrives, so the armed window is
    // registered but the strobe itself follows mem_ack directly.
    assign dr_en    = ctl_q.dr_arm & mem_ack;
    assign mem_req  = ctl_q.mem_req;
    assign mem_we   = ctl_q.mem_we;
    assign pc_en    = ctl_q.pc_en;
    assign pc_inc   = ctl_q.pc_inc;
    assign pc_write = ctl_q.pc_write;
    assign ar_en    = ctl_q.ar_en;
    assign ar_src   = ctl_q.ar_src;
    assign rb_en    = ctl_q.rb_en;
    assign rb_rw    = ctl_q.rb_rw;
    assign rb_sel   = ctl_q.rb_sel;
    assign rb_setd0 = ctl_q.rb_setd0;
    assign rb_setd1 = ctl_q.rb_setd1;
    assign wb_src   = ctl_q.wb_src;
    assign halted   = ctl_q.halted;
    assign bus_err  = bus_err_q;
    assign illegal  = illegal_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control
// snapshots; a negedge monitor answers memory requests and pops/compares.
module tb_cpu_sequencer;

    localparam int TMO = 4;
    localparam logic [15:0] SCRAMBLE = 16'hE000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, pc_en, pc_inc, pc_write, ar_en, ar_src, dr_en;
    logic        rb_en, rb_rw, wb_src, halted, bus_err, illegal;
    logic [2:0]  rb_sel, rb_setd0, rb_setd1;
    logic [15:0] retired;

    cpu_sequencer #(
        .MEM_TIMEOUT(TMO),
        .CNT_W      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .pc_en    (pc_en),
        .pc_inc   (pc_inc),
        .pc_write (pc_write),
        .ar_en    (ar_en),
        .ar_src   (ar_src),
        .dr_en    (dr_en),
        .rb_en    (rb_en),
        .rb_rw    (rb_rw),
        .rb_sel   (rb_sel),
        .rb_setd0 (rb_setd0),
        .rb_setd1 (rb_setd1),
        .wb_src   (wb_src),
        .halted   (halted),
        .bus_err  (bus_err),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mem_req, mem_we, pc_en, pc_inc, pc_write, ar_en, ar_src, dr_en;
        logic        rb_en, rb_rw;
        logic [2:0]  rb_sel, rb_setd0, rb_setd1;
        logic        wb_src, halted, bus_err, illegal;
        logic [15:0] retired;
    } snap_t;

    typedef struct {
        snap_t       s;
        logic [15:0] nxt;
        string       tag;
    } entry_t;

    entry_t      sb[$];
    int          dq[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_ret = 16'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic snap_t sample();
        snap_t s;
        s.mem_req = mem_req;   s.mem_we = mem_we;     s.pc_en = pc_en;
        s.pc_inc = pc_inc;     s.pc_write = pc_write; s.ar_en = ar_en;
        s.ar_src = ar_src;     s.dr_en = dr_en;       s.rb_en = rb_en;
        s.rb_rw = rb_rw;       s.rb_sel = rb_sel;     s.rb_setd0 = rb_setd0;
        s.rb_setd1 = rb_setd1; s.wb_src = wb_src;     s.halted = halted;
        s.bus_err = bus_err;   s.illegal = illegal;   s.retired = retired;
        return s;
    endfunction

    function automatic snap_t idle();
        snap_t s;
        s = '0;
        s.retired = exp_ret;
        return s;
    endfunction

    task automatic push(input snap_t s, input logic [15:0] nxt, input string tag);
        entry_t e;
        e.s = s;
        e.nxt = nxt;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Expected cycles of one instruction; fd/md = cycle of fetch/data ack.
    task automatic plan(input logic [15:0] w, input int fd, input int md, input bit first);
        logic [3:0] op;
        logic [2:0] rd, rs1, rs2;
        snap_t      s;
        string      id;
        op = w[15:12]; rd = w[11:9]; rs1 = w[8:6]; rs2 = w[5:3];
        id = $sformatf("%h", w);
        dq.push_back(fd);
        s = idle(); s.ar_en = !first;
        push(s, w, {id, ".fetch"});
        for (int i = 1; i <= fd; i++) begin
            s = idle(); s.mem_req = 1'b1; s.dr_en = (i == fd);
            push(s, w, {id, ".fwait"});
        end
        s = idle(); s.pc_en = 1'b1; s.pc_inc = 1'b1;
        push(s, w, {id, ".decode"});
        s = idle();
        s.illegal = !(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF});
        case (op)
            4'h1: begin
                s.rb_en = 1'b1; s.rb_rw = 1'b1; s.rb_sel = rd;
                s.rb_setd0 = rs1; s.rb_setd1 = rs2;
            end
            4'h2, 4'h3: begin
                s.rb_en = 1'b1; s.rb_setd0 = rs1; s.ar_en = 1'b1; s.ar_src = 1'b1;
            end
            4'h4: begin
                s.rb_en = 1'b1; s.rb_setd0 = rs1; s.pc_en = 1'b1; s.pc_write = 1'b1;
            end
            default: ;
        endcase
        push(s, SCRAMBLE, {id, ".exec"});
        if (op == 4'h2 || op == 4'h3) begin
            dq.push_back(md);
            for (int i = 1; i <= md; i++) begin
                s = idle(); s.mem_req = 1'b1; s.mem_we = (op == 4'h3);
                s.dr_en = (op == 4'h2) && (i == md);
                if (op == 4'h3) begin
                    s.rb_en = 1'b1; s.rb_setd1 = rd;
                end
                push(s, SCRAMBLE, {id, ".mwait"});
            end
            if (op == 4'h2) begin
                s = idle(); s.rb_en = 1'b1; s.rb_rw = 1'b1; s.rb_sel = rd; s.wb_src = 1'b1;
                push(s, SCRAMBLE, {id, ".wb"});
            end
        end
        exp_ret = exp_ret + 16'd1;
        if (op == 4'hF) begin
            s = idle(); s.halted = 1'b1;
            push(s, SCRAMBLE, {id, ".halt"});
        end
    endtask

    task automatic plan_timeout();
        snap_t s;
        dq.push_back(0);
        s = idle();
        push(s, 16'h1298, "tmo.fetch");
        for (int i = 1; i <= TMO; i++) begin
            s = idle(); s.mem_req = 1'b1;
            push(s, 16'h1298, "tmo.fwait");
        end
        s = idle(); s.halted = 1'b1; s.bus_err = 1'b1;
        push(s, 16'h1298, "tmo.buserr");
    endtask

    task automatic halted_cycles(input int n);
        snap_t s;
        for (int i = 0; i < n; i++) begin
            s = idle(); s.halted = 1'b1;
            push(s, 16'h0000, "halted");
        end
    endtask

    task automatic drain(input int left, input int budget);
        int n;
        n = 0;
        while (sb.size() > left && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drain", 64'(sb.size()), 64'(left));
    endtask

    task automatic reset_dut();
        sb.delete();
        dq.delete();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst.out", 64'(sample()), 64'(0));
        exp_ret = 16'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Memory responder and scoreboard monitor.
    initial begin
        bit     active;
        int     cnt;
        int     dly;
        entry_t e;
        active = 1'b0;
        cnt = 0;
        dly = 0;
        forever begin
            @(negedge clk);
            if (!mem_req) begin
                active = 1'b0;
            end else if (!active) begin
                active = 1'b1;
                cnt = 0;
                dly = (dq.size() > 0) ? dq.pop_front() : 0;
            end
            if (active) cnt++;
            mem_ack = active && (dly > 0) && (cnt == dly);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.tag, 64'(sample()), 64'(e.s));
                instr = e.nxt;
            end
        end
    end

    initial begin
        reset_dut();
        plan(16'h1298, 2, 0, 1'b1);
        plan(16'h0000, 1, 0, 1'b0);
        plan(16'h4080, 1, 0, 1'b0);
        plan(16'h2A80, 2, 3, 1'b0);
        plan(16'h3C40, 1, 2, 1'b0);
        plan(16'h0000, TMO, 0, 1'b0);
        plan(16'h1FF8, 1, 0, 1'b0);
        drain(0, 500);

        reset_dut();
        plan(16'h7000, 1, 0, 1'b1);
        plan(16'hF000, 1, 0, 1'b0);
        halted_cycles(3);
        drain(0, 200);
        check("halt.retired", 64'(retired), 64'(2));

        reset_dut();
        plan_timeout();
        halted_cycles(3);
        drain(0, 200);

        reset_dut();
        plan(16'h0000, 1, 0, 1'b1);
        plan(16'h2A80, 1, 3, 1'b0);
        drain(3, 200);
        rst = 1'b1;
        sb.delete();
        dq.delete();
        @(negedge clk);
        #2;
        check("rst.mwait.req", 64'(mem_req), 64'(0));
        check("rst.mwait.ret", 64'(retired), 64'(0));
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
